// File: rtl/conv5x5_engine_if.sv
// Handshake and coefficient-write bus for conv5x5_engine: window in, coefficient writes,
// filtered pixel out.
interface conv5x5_engine_if #(
   parameter int unsigned COEF_W = 6
);
   logic [99:0]              data_chunk;
   logic                     chunk_valid;
   logic                     chunk_ready;
   logic                     coef_we;
   logic [4:0]               coef_addr;
   logic signed [COEF_W-1:0] coef_data;
   logic [3:0]               pixel_out;
   logic                     pixel_valid;
   logic                     out_ready;

   modport master (
      output data_chunk, chunk_valid, coef_we, coef_addr, coef_data, out_ready,
      input  chunk_ready, pixel_out, pixel_valid
   );

   modport slave (
      input  data_chunk, chunk_valid, coef_we, coef_addr, coef_data, out_ready,
      output chunk_ready, pixel_out, pixel_valid
   );
endinterface

// File: rtl/conv5x5_engine.sv
// 5x5 convolution engine: one kernel row per MAC cycle, then shift/clamp to a 4-bit pixel.
// Define CONV_ABS_EN to clamp the magnitude of the shifted sum instead of flooring at 0.
module conv5x5_engine #(
   parameter int          SHIFT  = 4,
   parameter int unsigned COEF_W = 6
) (
   input logic             clk,
   input logic             reset,
   conv5x5_engine_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StMac, StNorm, StOut} state_e;

   state_e                   state_q, state_d;
   logic [99:0]              win_q;
   logic signed [COEF_W-1:0] coef_q [25];
   logic signed [COEF_W-1:0] kern_q [25];
   logic signed [15:0]       acc_q;
   logic [2:0]               row_q;
   logic [3:0]               pix_q;
   logic                     valid_q;

   logic                     coef_wr;
   logic signed [15:0]       row_sum;
   logic signed [15:0]       shifted;
   logic signed [15:0]       mag;
   logic [3:0]               pix_d;
   logic [4:0]               idx;
   logic [3:0]               pix;
   logic signed [COEF_W-1:0] cf;
   logic signed [15:0]       pix_ext;
   logic signed [15:0]       cf_ext;

   assign coef_wr         = (state_q == StIdle) && bus.coef_we && (bus.coef_addr < 5'd25);
   assign bus.chunk_ready = reset && (state_q == StIdle);
   assign bus.pixel_out   = pix_q;
   assign bus.pixel_valid = valid_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.chunk_valid) state_d = StMac;
         StMac:   if (row_q == 3'd4) state_d = StNorm;
         StNorm:  state_d = StOut;
         StOut:   if (bus.out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      row_sum = '0;
      idx     = '0;
      pix     = '0;
      cf      = '0;
      pix_ext = '0;
      cf_ext  = '0;
      for (int c = 0; c < 5; c++) begin
         idx     = 5'(row_q) * 5'd5 + 5'(c);
         pix     = win_q[{idx, 2'b00} +: 4];
         cf      = kern_q[idx];
         pix_ext = {12'b0, pix};
         cf_ext  = {{(16 - COEF_W){cf[COEF_W-1]}}, cf};
         row_sum = row_sum + pix_ext * cf_ext;
      end
   end

   always_comb begin
      shifted = acc_q >>> SHIFT;
`ifdef CONV_ABS_EN
      mag = (shifted < 0) ? -shifted : shifted;
`else
      mag = (shifted < 0) ? 16'sd0 : shifted;
`endif
      pix_d = (mag > 16'sd15) ? 4'd15 : mag[3:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         acc_q   <= '0;
         row_q   <= '0;
         pix_q   <= '0;
         valid_q <= 1'b0;
         for (int k = 0; k < 25; k++) coef_q[k] <= '0;
         coef_q[12] <= COEF_W'(16);
      end else begin
         if (coef_wr) coef_q[bus.coef_addr] <= bus.coef_data;
         unique case (state_q)
            StIdle: begin
               if (bus.chunk_valid) begin
                  win_q  <= bus.data_chunk;
                  // Snapshot the kernel so a same-edge coefficient write cannot leak in.
                  kern_q <= coef_q;
                  acc_q  <= '0;
                  row_q  <= '0;
               end
            end
            StMac: begin
               acc_q <= acc_q + row_sum;
               row_q <= row_q + 3'd1;
            end
            StNorm: begin
               pix_q   <= pix_d;
               valid_q <= 1'b1;
            end
            StOut: if (bus.out_ready) valid_q <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_conv5x5_engine.sv
// Directed bench for conv5x5_engine: hand-computed windows, handshake stalls,
// coefficient write corner cases and mid-operation reset.
module tb_conv5x5_engine;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   int   pix, lat;

   conv5x5_engine_if #(.COEF_W(6)) bus ();

   conv5x5_engine #(.SHIFT(4), .COEF_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs_v, input int exp_v);
      n_cmp++;
      if (obs_v != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, obs_v, exp_v);
      end
   endtask

   function automatic logic [99:0] fill(input logic [3:0] v);
      logic [99:0] r;
      for (int k = 0; k < 25; k++) r[4*k +: 4] = v;
      return r;
   endfunction

   function automatic logic [99:0] put(input logic [99:0] c, input int k, input logic [3:0] v);
      logic [99:0] r;
      r = c;
      r[4*k +: 4] = v;
      return r;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_chunk_ready", bus.chunk_ready, 0);
      check("rst_pixel_valid", bus.pixel_valid, 0);
      check("rst_pixel_out", bus.pixel_out, 0);
      reset = 1'b1;
      #1;
      check("rel_chunk_ready", bus.chunk_ready, 1);
   endtask

   task automatic write_coef(input int addr, input int data);
      @(negedge clk);
      bus.coef_we   = 1'b1;
      bus.coef_addr = 5'(addr);
      bus.coef_data = 6'(data);
      @(posedge clk);
      @(negedge clk);
      bus.coef_we = 1'b0;
   endtask

   task automatic zero_kernel();
      for (int k = 0; k < 25; k++) write_coef(k, 0);
   endtask

   // Accepts one window, optionally writing a coefficient on the accept edge (acc_we)
   // or on the first MAC edge (mac_we, addr 12 <- 0), then acknowledges the result.
   task automatic run_window(input logic [99:0] chunk, input logic acc_we, input int acc_addr,
                             input int acc_data, input logic mac_we,
                             output int pix_o, output int lat_o);
      @(negedge clk);
      check("idle_chunk_ready", bus.chunk_ready, 1);
      bus.data_chunk  = chunk;
      bus.chunk_valid = 1'b1;
      bus.coef_we     = acc_we;
      bus.coef_addr   = 5'(acc_addr);
      bus.coef_data   = 6'(acc_data);
      @(posedge clk);
      @(negedge clk);
      bus.chunk_valid = 1'b0;
      bus.coef_we     = mac_we;
      bus.coef_addr   = 5'd12;
      bus.coef_data   = 6'd0;
      check("busy_chunk_ready", bus.chunk_ready, 0);
      lat_o = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         bus.coef_we = 1'b0;
         if (bus.pixel_valid) begin
            lat_o = i;
            break;
         end
      end
      check("latency", lat_o, 6);
      pix_o = bus.pixel_out;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("ack_pixel_valid", bus.pixel_valid, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1);
   end

   initial begin
      logic [99:0] c_id;
      logic [99:0] c;
      bit          seen;
      reset           = 1'b1;
      bus.data_chunk  = '0;
      bus.chunk_valid = 1'b0;
      bus.coef_we     = 1'b0;
      bus.coef_addr   = '0;
      bus.coef_data   = '0;
      bus.out_ready   = 1'b0;
      c_id = put(fill(4'h7), 12, 4'h9);

      do_reset();
      run_window(c_id, 1'b0, 0, 0, 1'b0, pix, lat);
      check("identity", pix, 9);

      // Same-edge write of coef[12]=0: this window uses the old kernel, the next one the new.
      run_window(c_id, 1'b1, 12, 0, 1'b0, pix, lat);
      check("same_edge_prewrite", pix, 9);
      run_window(c_id, 1'b0, 0, 0, 1'b0, pix, lat);
      check("same_edge_postwrite", pix, 0);

      for (int k = 0; k < 25; k++) write_coef(k, 1);
      run_window(fill(4'h2), 1'b0, 0, 0, 1'b0, pix, lat);
      check("ones_x2", pix, 3);
      run_window(fill(4'hF), 1'b0, 0, 0, 1'b0, pix, lat);
      check("ones_xf_clamp", pix, 15);

      zero_kernel();
      write_coef(12, -16);
      run_window(put(fill(4'h3), 12, 4'h5), 1'b0, 0, 0, 1'b0, pix, lat);
`ifdef CONV_ABS_EN
      check("neg16_centre5", pix, 5);
`else
      check("neg16_centre5", pix, 0);
`endif

      // -20 >>> 4 floors to -2.
      write_coef(12, -4);
      run_window(put(fill(4'h0), 12, 4'h5), 1'b0, 0, 0, 1'b0, pix, lat);
`ifdef CONV_ABS_EN
      check("floor_shift", pix, 2);
`else
      check("floor_shift", pix, 0);
`endif

      // 8*5 + 2*16 + 4*(-3) = 60 -> 3
      write_coef(0, 5);
      write_coef(12, 16);
      write_coef(24, -3);
      c = put(put(put(fill(4'h0), 0, 4'h8), 12, 4'h2), 24, 4'h4);
      run_window(c, 1'b0, 0, 0, 1'b0, pix, lat);
      check("mixed_kernel", pix, 3);

      // Output stall with a competing window offered.
      do_reset();
      @(negedge clk);
      bus.data_chunk  = c_id;
      bus.chunk_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.chunk_valid = 1'b0;
      for (int i = 0; i < 20 && !bus.pixel_valid; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("stall_valid_rise", bus.pixel_valid, 1);
      for (int i = 0; i < 10; i++) begin
         bus.data_chunk  = put(fill(4'h3), 12, 4'h3);
         bus.chunk_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check("stall_pixel_out", bus.pixel_out, 9);
         check("stall_pixel_valid", bus.pixel_valid, 1);
         check("stall_chunk_ready", bus.chunk_ready, 0);
      end
      bus.chunk_valid = 1'b0;
      bus.out_ready   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("stall_release_valid", bus.pixel_valid, 0);
      check("stall_release_ready", bus.chunk_ready, 1);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.pixel_valid) seen = 1'b1;
      end
      check("stall_no_second_window", seen, 0);

      // Reset on the third MAC cycle with a non-identity kernel loaded.
      for (int k = 0; k < 25; k++) write_coef(k, 1);
      @(negedge clk);
      bus.data_chunk  = c_id;
      bus.chunk_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.chunk_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_chunk_ready", bus.chunk_ready, 0);
      reset = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.pixel_valid) seen = 1'b1;
      end
      check("midrst_no_output", seen, 0);
      check("midrst_chunk_ready_rel", bus.chunk_ready, 1);
      run_window(c_id, 1'b0, 0, 0, 1'b0, pix, lat);
      check("midrst_identity", pix, 9);

      // Out-of-range address and a write during MAC must both be dropped.
      write_coef(27, 31);
      run_window(c_id, 1'b0, 0, 0, 1'b1, pix, lat);
      check("ignored_writes_a", pix, 9);
      run_window(c_id, 1'b0, 0, 0, 1'b0, pix, lat);
      check("ignored_writes_b", pix, 9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/conv5x5_engine.md
CONV5X5_ENGINE -- requirements
Module: conv5x5_engine

Interface
REQ-001 Parameter SHIFT, default 4: arithmetic right-shift applied to the accumulator before clamping.
REQ-002 Parameter COEF_W, default 6: signed coefficient width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; asserted when 0, sampled on clk rising edge.
REQ-005 data_chunk  input  100  5x5 window of 4-bit unsigned pixels from framebuffer; pixel k=row*5+col at bits [4k+3:4k], row 0 = top.
REQ-006 chunk_valid  input  1  data_chunk valid; driven from framebuffer data_ready.
REQ-007 chunk_ready  output  1  engine can accept a window this cycle.
REQ-008 coef_we  input  1  coefficient write strobe.
REQ-009 coef_addr  input  5  coefficient index 0..24, same ordering as pixels.
REQ-010 coef_data  input  COEF_W  signed two's-complement coefficient.
REQ-011 pixel_out  output  4  filtered, clamped output pixel.
REQ-012 pixel_valid  output  1  pixel_out valid.
REQ-013 out_ready  input  1  downstream accepts pixel_out.

Function
REQ-014 The engine SHALL implement the FSM IDLE -> MAC -> NORM -> OUT -> IDLE.
REQ-015 In IDLE, chunk_ready SHALL be 1; in all other states it SHALL be 0.
REQ-016 On an edge with chunk_valid=1 in IDLE, the engine SHALL register data_chunk, clear the 16-bit signed accumulator, set row counter to 0, and enter MAC.
REQ-017 In MAC, each edge SHALL add the five products pixel*coef of the current row to the accumulator; after row 4 (5th MAC edge) the state SHALL be NORM.
REQ-018 Products SHALL be zero-extended 4-bit pixel times sign-extended COEF_W coefficient, summed in 16-bit signed with no overflow (|sum| <= 12000 at COEF_W=6).
REQ-019 In NORM, one edge SHALL register pixel_out = clamp(acc >>> SHIFT, 0, 15) (floor shift), set pixel_valid=1, and enter OUT.
REQ-020 pixel_valid SHALL rise exactly 6 cycles after the accepting edge.
REQ-021 In OUT, pixel_out and pixel_valid SHALL hold stable until an edge with out_ready=1, which SHALL clear pixel_valid and return to IDLE.
REQ-022 chunk_valid outside IDLE SHALL be ignored; the window is not buffered.
REQ-023 Coefficient write SHALL occur on an edge with coef_we=1, state IDLE, coef_addr<25; writes with coef_addr 25..31 or state not IDLE SHALL be ignored.
REQ-024 A coefficient write and window accept on the same IDLE edge: the computation SHALL use the pre-write coefficients.
REQ-025 Minimum per-window period SHALL be 8 cycles (accept, 5 MAC, NORM, OUT with out_ready=1).

Reset
REQ-026 While reset=0 at an edge: state IDLE, accumulator 0, row counter 0, pixel_out 0, pixel_valid 0, chunk_ready 0 during reset, 1 on first cycle after release.
REQ-027 Reset SHALL load the identity kernel: coef[12]=16, all others 0 (identity at SHIFT=4).
REQ-028 Reset mid-operation SHALL abandon the window with no output produced.

Configuration
REQ-029 Macro CONV_ABS_EN: when defined, NORM SHALL clamp |acc >>> SHIFT| to 0..15 (edge magnitude); when undefined, negative results SHALL clamp to 0.

Verification
REQ-030 Post-reset identity kernel, all pixels 0x7, centre 0x9 -> pixel_out=9, pixel_valid exactly 6 cycles after accept.
REQ-031 All coefs 1, all pixels 0x2 -> 50>>>4 -> pixel_out=3; all pixels 0xF -> 375>>>4=23 -> pixel_out=15 (clamp).
REQ-032 coef[12]=-16, others 0, centre pixel 5 -> -80>>>4=-5 -> pixel_out=0; with CONV_ABS_EN -> pixel_out=5.
REQ-033 out_ready held 0 for 10 cycles -> pixel_out/pixel_valid stable, chunk_ready=0, second chunk_valid not accepted; out_ready=1 -> IDLE next edge.
REQ-034 Reset=0 on 3rd MAC cycle -> pixel_valid stays 0, chunk_ready=1 after release, next window computed with identity kernel.
REQ-035 Writes to coef_addr 27 and during MAC (addr 12, data 0) -> ignored; identity output unchanged.
